// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone prefix adder.
// Stage bundles are sized for MAX_WIDTH; the adder uses only the low WIDTH bits of each field.
package prefix_adder_pkg;

  localparam int MAX_WIDTH = 64;

  typedef logic [MAX_WIDTH-1:0] vec_t;

  // One pipeline stage: group generate/propagate so far, bitwise propagate for the
  // final sum, and the carry-in needed for bit 0 and the overflow term.
  typedef struct packed {
    logic valid;
    logic cin;
    vec_t grp_g;
    vec_t grp_p;
    vec_t p;
  } stage_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int num_stages(input int width, input int levels_per_stage);
    int n;
    n = (clog2(width) + levels_per_stage - 1) / levels_per_stage;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone black cell combining a high group with the adjacent lower group.
// A gray cell is this same cell with p_out left unconsumed downstream.
module prefix_gp_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder S = X + Y + c_in with a valid/ready stream and global stall.
// Define PREFIX_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH            = 6,
  parameter int LEVELS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   S
`ifdef PREFIX_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NUM_LEVELS = clog2(WIDTH);
  localparam int NUM_STAGES = num_stages(WIDTH, LEVELS_PER_STAGE);
  localparam int NUM_REGS   = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  logic             adv;
  logic [WIDTH-1:0] gv [NUM_LEVELS+1];
  logic [WIDTH-1:0] pv [NUM_LEVELS+1];
  logic             src_valid [NUM_STAGES];
  logic             src_cin   [NUM_STAGES];
  logic [WIDTH-1:0] src_p     [NUM_STAGES];
  stage_t           st_q      [NUM_REGS];
  logic [WIDTH:0]   carry;
  logic [WIDTH:0]   sum_d;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Carry-in is folded into bit 0 so every prefix G[i:0] is the true carry out of bit i.
  assign gv[0] = (X & Y) | WIDTH'((X[0] ^ Y[0]) & c_in);
  assign pv[0] = X ^ Y;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_src
    if (s == 0) begin : g_from_port
      assign src_valid[s] = in_valid;
      assign src_cin[s]   = c_in;
      assign src_p[s]     = X ^ Y;
    end else begin : g_from_reg
      assign src_valid[s] = st_q[s-1].valid;
      assign src_cin[s]   = st_q[s-1].cin;
      assign src_p[s]     = st_q[s-1].p[WIDTH-1:0];
    end
  end

  for (genvar k = 0; k < NUM_LEVELS; k++) begin : g_lvl
    localparam int STG  = k / LEVELS_PER_STAGE;
    localparam int SPAN = 1 << k;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;

    // The first level of every later stage reads the register bank, not the previous level.
    if ((k % LEVELS_PER_STAGE == 0) && (STG > 0)) begin : g_reg_in
      assign g_in = st_q[STG-1].grp_g[WIDTH-1:0];
      assign p_in = st_q[STG-1].grp_p[WIDTH-1:0];
    end else begin : g_comb_in
      assign g_in = gv[k];
      assign p_in = pv[k];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        prefix_gp_cell u_cell (
          .g_hi  (g_in[i]),
          .p_hi  (p_in[i]),
          .g_lo  (g_in[i-SPAN]),
          .p_lo  (p_in[i-SPAN]),
          .g_out (gv[k+1][i]),
          .p_out (pv[k+1][i])
        );
      end else begin : g_pass
        assign gv[k+1][i] = g_in[i];
        assign pv[k+1][i] = p_in[i];
      end
    end
  end

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out.
  assign carry = {gv[NUM_LEVELS], src_cin[NUM_STAGES-1]};
  assign sum_d = {carry[WIDTH], src_p[NUM_STAGES-1] ^ carry[WIDTH-1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let a stage see its predecessor's new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too so bubbles and post-reset S are
      // deterministic; this is a handful of flops, not a memory array.
      for (int s = 0; s < NUM_REGS; s++) st_q[s] <= '0;
      out_valid <= 1'b0;
      S         <= '0;
`ifdef PREFIX_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (adv) begin
      for (int s = 0; s < NUM_STAGES - 1; s++) begin
        st_q[s].valid <= src_valid[s];
        st_q[s].cin   <= src_cin[s];
        st_q[s].grp_g <= vec_t'(gv[(s+1)*LEVELS_PER_STAGE]);
        st_q[s].grp_p <= vec_t'(pv[(s+1)*LEVELS_PER_STAGE]);
        st_q[s].p     <= vec_t'(src_p[s]);
      end
      out_valid <= src_valid[NUM_STAGES-1];
      S         <= sum_d;
`ifdef PREFIX_ADDER_OVF_EN
      ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder: directed, exhaustive, backpressure,
// random-handshake and mid-flight reset scenarios against an arithmetic scoreboard.
module tb_pipelined_prefix_adder;

  localparam int W   = 6;
  localparam int LPS = 1;
  localparam int LVL = $clog2(W);
  localparam int LAT = (((LVL + LPS - 1) / LPS) < 1) ? 1 : ((LVL + LPS - 1) / LPS);
`ifdef PREFIX_ADDER_OVF_EN
  localparam bit CHECK_OVF = 1'b1;
`else
  localparam bit CHECK_OVF = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   S;
  logic         ovf;

  pipelined_prefix_adder #(.WIDTH(W), .LEVELS_PER_STAGE(LPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S)
`ifdef PREFIX_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef PREFIX_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] s;
    logic       ovf;
  } exp_t;

  typedef struct {
    bit         pop;
    bit         push;
    logic       ovalid;
    logic       iready;
    logic [W:0] s;
    logic       ovf;
  } obs_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fails;

  // Reference: plain integer arithmetic on the operands, signed range test for overflow.
  function automatic exp_t ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    int   sx;
    int   sy;
    int   total;
    e.s   = (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
    sx    = $signed(x);
    sy    = $signed(y);
    total = sx + sy + int'(c);
    e.ovf = (total > (2 ** (W - 1)) - 1) || (total < -(2 ** (W - 1)));
    return e;
  endfunction

  task automatic cycle(output obs_t ob);
    @(negedge clk);
    ob.pop    = (out_valid === 1'b1) && (out_ready === 1'b1);
    ob.push   = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst === 1'b0);
    ob.ovalid = out_valid;
    ob.iready = in_ready;
    ob.s      = S;
    ob.ovf    = ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    X    = W'($urandom);
    Y    = W'($urandom);
    c_in = 1'($urandom);
  endtask

  task automatic test_reset();
    obs_t ob;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_random();
      cycle(ob);
      n_checks++;
      if (ob.ovalid !== 1'b0 || ob.s !== '0 || ob.iready !== 1'b1) begin
        n_fails++;
        $display("FAIL reset_state: got out_valid=%b S=%0h in_ready=%b expected 0 0 1", ob.ovalid, ob.s, ob.iready);
      end
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      cycle(ob);
      n_checks++;
      if (ob.ovalid !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_no_output: got out_valid=%b expected 0 at cycle %0d", ob.ovalid, i);
      end
    end
  endtask

  task automatic test_basic(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input logic [W:0] lit_s, input string name);
    obs_t ob;
    exp_t e;
    int   edges;
    bit   got;
    X = x; Y = y; c_in = c; in_valid = 1'b1; out_ready = 1'b1;
    e = ref_sum(x, y, c);
    cycle(ob);
    n_checks++;
    if (!ob.push) begin
      n_fails++;
      $display("FAIL %s_accept: got in_ready=%b expected 1", name, ob.iready);
    end
    in_valid = 1'b0;
    edges = 1;
    got   = 1'b0;
    while (!got && edges <= LAT + 5) begin
      cycle(ob);
      if (ob.pop) got = 1'b1;
      else edges++;
    end
    n_checks++;
    if (!got || edges != LAT) begin
      n_fails++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0b) expected %0d", name, edges, got, LAT);
    end
    n_checks++;
    if (ob.s !== lit_s || ob.s !== e.s) begin
      n_fails++;
      $display("FAIL %s_sum: got %b expected %b", name, ob.s, lit_s);
    end
    if (CHECK_OVF) begin
      n_checks++;
      if (ob.ovf !== e.ovf) begin
        n_fails++;
        $display("FAIL %s_ovf: got %b expected %b", name, ob.ovf, e.ovf);
      end
    end
  endtask

  task automatic test_exhaustive();
    obs_t        ob;
    exp_t        e;
    logic [12:0] v;
    int          pops_in_loop;
    int          pops;
    int          guard;
    pops_in_loop = 0;
    pops = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      v = i[12:0];
      c_in = v[12]; X = v[11:6]; Y = v[5:0];
      cycle(ob);
      n_checks++;
      if (!ob.push) begin
        n_fails++;
        $display("FAIL exh_in_ready: got 0 expected 1 at beat %0d", i);
      end else begin
        sb.push_back(ref_sum(v[11:6], v[5:0], v[12]));
      end
      if (ob.pop) begin
        pops_in_loop++;
        pops++;
        n_checks++;
        e = sb.pop_front();
        if (ob.s !== e.s || (CHECK_OVF && ob.ovf !== e.ovf)) begin
          n_fails++;
          $display("FAIL exh_result: got S=%0h ovf=%b expected S=%0h ovf=%b", ob.s, ob.ovf, e.s, e.ovf);
        end
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < LAT + 10) begin
      cycle(ob);
      guard++;
      if (ob.pop) begin
        pops++;
        n_checks++;
        e = sb.pop_front();
        if (ob.s !== e.s || (CHECK_OVF && ob.ovf !== e.ovf)) begin
          n_fails++;
          $display("FAIL exh_drain: got S=%0h ovf=%b expected S=%0h ovf=%b", ob.s, ob.ovf, e.s, e.ovf);
        end
      end
    end
    n_checks++;
    if (pops_in_loop != 8192 - LAT) begin
      n_fails++;
      $display("FAIL exh_throughput: got %0d results while streaming expected %0d", pops_in_loop, 8192 - LAT);
    end
    n_checks++;
    if (pops != 8192 || sb.size() != 0) begin
      n_fails++;
      $display("FAIL exh_count: got %0d results expected 8192", pops);
      sb.delete();
    end
  endtask

  task automatic test_backpressure();
    obs_t ob;
    exp_t e;
    int   pops;
    int   guard;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      cycle(ob);
      if (ob.push) sb.push_back(ref_sum(X, Y, c_in));
    end
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(ob);
      n_checks++;
      if (ob.iready !== 1'b0 || ob.ovalid !== 1'b1 || sb.size() == 0 || ob.s !== sb[0].s) begin
        n_fails++;
        $display("FAIL bp_stall: got in_ready=%b out_valid=%b S=%0h expected 0 1 %0h",
                 ob.iready, ob.ovalid, ob.s, (sb.size() > 0) ? sb[0].s : '0);
      end
    end
    out_ready = 1'b1;
    pops = 0;
    guard = 0;
    while (guard < LAT + 10) begin
      cycle(ob);
      guard++;
      if (ob.pop) begin
        pops++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fails++;
          $display("FAIL bp_extra: got S=%0h expected no further output", ob.s);
        end else begin
          e = sb.pop_front();
          if (ob.s !== e.s || (CHECK_OVF && ob.ovf !== e.ovf)) begin
            n_fails++;
            $display("FAIL bp_result: got S=%0h ovf=%b expected S=%0h ovf=%b", ob.s, ob.ovf, e.s, e.ovf);
          end
        end
      end
    end
    n_checks++;
    if (pops != 3) begin
      n_fails++;
      $display("FAIL bp_count: got %0d results expected 3", pops);
    end
    sb.delete();
  endtask

  task automatic test_random_handshake();
    obs_t ob;
    exp_t e;
    int   guard;
    for (int i = 0; i < 400; i++) begin
      drive_random();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(ob);
      if (ob.pop) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fails++;
          $display("FAIL rand_extra: got S=%0h expected no output", ob.s);
        end else begin
          e = sb.pop_front();
          if (ob.s !== e.s || (CHECK_OVF && ob.ovf !== e.ovf)) begin
            n_fails++;
            $display("FAIL rand_result: got S=%0h ovf=%b expected S=%0h ovf=%b", ob.s, ob.ovf, e.s, e.ovf);
          end
        end
      end
      if (ob.push) sb.push_back(ref_sum(X, Y, c_in));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (sb.size() > 0 && guard < LAT + 10) begin
      cycle(ob);
      guard++;
      if (ob.pop) begin
        n_checks++;
        e = sb.pop_front();
        if (ob.s !== e.s || (CHECK_OVF && ob.ovf !== e.ovf)) begin
          n_fails++;
          $display("FAIL rand_drain: got S=%0h ovf=%b expected S=%0h ovf=%b", ob.s, ob.ovf, e.s, e.ovf);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL rand_lost: got %0d beats missing expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_midflight_reset();
    obs_t ob;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_random();
      cycle(ob);
    end
    rst = 1'b1;
    drive_random();
    cycle(ob);
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < LAT + 6; i++) begin
      cycle(ob);
      n_checks++;
      if (ob.ovalid !== 1'b0) begin
        n_fails++;
        $display("FAIL midrst_no_output: got out_valid=%b S=%0h expected 0 at cycle %0d", ob.ovalid, ob.s, i);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    X = '0; Y = '0; c_in = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic(6'b111111, 6'b000001, 1'b0, 7'b1000000, "carry_chain");
    test_basic(6'b000000, 6'b000000, 1'b1, 7'b0000001, "cin_only");
`ifdef PREFIX_ADDER_OVF_EN
    test_basic(6'b011111, 6'b000001, 1'b0, 7'b0100000, "ovf_pos");
    test_basic(6'b100000, 6'b100000, 1'b0, 7'b1000000, "ovf_neg");
    test_basic(6'b111111, 6'b000001, 1'b0, 7'b1000000, "ovf_none");
`endif
    test_exhaustive();
    test_backpressure();
    test_random_handshake();
    test_midflight_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipelined_prefix_adder.md
# pipelined_prefix_adder

Parametrised, pipelined Kogge-Stone prefix adder: the next generation of the team's 6-bit combinational `prefix_adder`. Adds two WIDTH-bit operands plus carry-in and returns a WIDTH+1-bit sum. Prefix levels are grouped into register stages under a valid/ready handshake with full backpressure. Sits in datapaths needing a timing-closed adder with a stream interface.

## Interface
- `WIDTH`, default 6: operand width, ≥1.
- `LEVELS_PER_STAGE`, default 1: prefix levels per pipeline register stage, ≥1.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  pipeline can accept a beat this cycle.
- `X`  in  WIDTH  operand A, unsigned (two's complement when overflow feature built).
- `Y`  in  WIDTH  operand B.
- `c_in`  in  1  carry-in.
- `out_valid`  out  1  result present on `S`.
- `out_ready`  in  1  consumer accepts result.
- `S`  out  WIDTH+1  sum; MSB is carry-out.
- `ovf`  out  1  signed overflow; present only with `PREFIX_ADDER_OVF_EN`.

## Operation
- L = clog2(WIDTH) prefix levels (L=0 when WIDTH=1). NUM_STAGES = max(1, ceil(L/LEVELS_PER_STAGE)).
- Stage 1 forms bitwise g=X&Y, p=X^Y, folds `c_in` in as carry into bit 0, then runs its prefix levels. Each later stage runs the next LEVELS_PER_STAGE Kogge-Stone levels at span 2^k.
- The final stage forms S[i]=p[i]^G[i-1:0], with G[-1]=c_in, and S[WIDTH]=G[WIDTH-1:0]. It registers S into the output register.
- Result is exact: S = X + Y + c_in, no truncation, mod 2^(WIDTH+1) never reached.
- Each stage carries its own valid bit, and p is carried forward with the prefix state.
- Global advance: `adv = !out_valid | out_ready`. When adv=1, every stage loads its predecessor and stage 1 loads the inputs with valid=`in_valid`.
- When adv=0, all stages hold, including data and valid.
- `in_ready = adv`, combinational from `out_ready` and `out_valid`. An input is accepted iff `in_valid & in_ready`.
- Bubbles propagate as valid=0. Their data is don't-care but deterministic.
- Ordering is strictly FIFO. There is no reordering, drop or duplication.

## Timing
- Latency NUM_STAGES cycles from acceptance to `out_valid` with S. WIDTH=6 / LEVELS_PER_STAGE=1 gives 3; LEVELS_PER_STAGE≥3 gives 1.
- Throughput is 1 beat/cycle while `out_ready`=1.
- Reset values: all valid bits 0, `out_valid`=0, `S`=0, `ovf`=0, all stage data 0. `in_ready`=1 during and after reset.
- `rst` has priority over `adv`. Reset mid-operation discards all in-flight beats, none emerge, and `out_valid`=0 the cycle after the reset edge.
- While `out_valid`=1 and `out_ready`=0, `S`/`ovf` are stable.
- Simultaneous output pop and input push is legal and lossless.
- Input accepted in the reset cycle is discarded.

## Configuration
- `PREFIX_ADDER_OVF_EN` defined: port `ovf` exists.
  - ovf = carry into bit WIDTH-1 XOR carry-out, i.e. signed overflow of X+Y+c_in.
  - Pipelined alongside S with identical latency and stall behaviour; reset 0.
- Undefined: no `ovf` port and no overflow logic or registers.

## Structure
- Package `prefix_adder_pkg`:
  - constant function `clog2`
  - function computing NUM_STAGES from WIDTH/LEVELS_PER_STAGE
  - typedef for a stage's {valid, G, P, p} bundle
- One sub-module `prefix_gp_cell`: black cell G=Gh|(Ph&Gl), P=Ph&Pl. It is instantiated per bit per level via generate. Gray cells are the same module with the P output unused.

## Test plan
- Reset: `rst`=1 for 2 cycles with `in_valid`=1 -> `out_valid`=0, S=0, `in_ready`=1, and no result appears afterwards.
- WIDTH=6: X=6'b111111, Y=6'b000001, c_in=0, out_ready=1 -> 3 cycles later `out_valid`=1, S=7'b1000000. X=0, Y=0, c_in=1 -> S=7'b0000001.
- Exhaustive stream: all 2^13 {c_in,X,Y} back-to-back, out_ready=1 -> one result/cycle, in order, each equal to X+Y+c_in.
- Backpressure: accept 3 beats, then out_ready=0 for 5 cycles -> `in_ready`=0, S held stable. Release -> the 3 results emerge in order, with no loss or duplication.
- Mid-flight reset: 2 beats in flight, `rst` pulse 1 cycle -> `out_valid`=0 the next cycle and neither result ever appears.
- With `PREFIX_ADDER_OVF_EN`: X=6'b011111, Y=6'b000001 -> ovf=1. X=6'b100000, Y=6'b100000 -> S=7'b1000000, ovf=1. X=6'b111111, Y=6'b000001 -> ovf=0.
